// File: rtl/dot_prod_host.sv
// Host front end for the dot-product kernel: streams element pairs into both
// array banks, zero-pads the tail, starts the kernel and returns its result.
module dot_prod_host #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1000,
  parameter int DATA_W  = 27,
  parameter int ACC_W   = 64,
  parameter int TIMEOUT = 1 << 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_a,
  input  logic signed [DATA_W-1:0] s_b,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [ACC_W-1:0]  m_result,
  output logic [31:0]              m_cycles,
  output logic                     m_error,
  output logic                     controlArr,
  output logic                     r_enable,
  output logic [ADDR_W-1:0]        init_i_t_a,
  output logic [ACC_W-1:0]         init_acc_t_a,
  input  logic                     w_enable,
  input  logic signed [ACC_W-1:0]  result,
  output logic                     controlArrWEnable_a,
  output logic                     controlArrWEnable_b,
  output logic [ADDR_W-1:0]        controlArrAddr_a,
  output logic [ADDR_W-1:0]        controlArrAddr_b,
  output logic signed [DATA_W-1:0] controlArrWData_a,
  output logic signed [DATA_W-1:0] controlArrWData_b
);

  typedef enum logic [2:0] {ST_LOAD, ST_PAD, ST_KICK, ST_RUN, ST_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       TIMEOUT_CNT = 32'(TIMEOUT);

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         idx_q, idx_d;
  logic [31:0]               cnt_q, cnt_d;
  logic [31:0]               cnt_inc;
  logic                      s_ready_q, s_ready_d;
  logic                      ctrl_q, ctrl_d;
  logic                      r_en_q, r_en_d;
  logic                      wen_q, wen_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic signed [DATA_W-1:0]  wa_q, wa_d;
  logic signed [DATA_W-1:0]  wb_q, wb_d;
  logic                      m_valid_q, m_valid_d;
  logic signed [ACC_W-1:0]   m_result_q, m_result_d;
  logic [31:0]               m_cycles_q, m_cycles_d;
  logic                      m_error_q, m_error_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cnt_inc    = cnt_q + 32'd1;
    ctrl_d     = ctrl_q;
    r_en_d     = 1'b0;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    wa_d       = wa_q;
    wb_d       = wb_q;
    m_valid_d  = m_valid_q;
    m_result_d = m_result_q;
    m_cycles_d = m_cycles_q;
    m_error_d  = m_error_q;

    case (state_q)
      ST_LOAD: begin
        if (s_valid && s_ready_q) begin
          wen_d  = 1'b1;
          addr_d = idx_q;
          wa_d   = s_a;
          wb_d   = s_b;
          // The last array slot closes the job even without s_last.
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_KICK;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
            if (s_last) begin
              state_d = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        wen_d  = 1'b1;
        addr_d = idx_q;
        wa_d   = '0;
        wb_d   = '0;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_KICK;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      ST_KICK: begin
        ctrl_d  = 1'b0;
        r_en_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (w_enable) begin
          m_valid_d  = 1'b1;
          m_result_d = result;
          m_cycles_d = cnt_inc;
          m_error_d  = 1'b0;
          state_d    = ST_DONE;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          m_valid_d  = 1'b1;
          m_result_d = '0;
          m_cycles_d = cnt_inc;
          m_error_d  = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          idx_d     = '0;
          ctrl_d    = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase

    s_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      cnt_q      <= '0;
      s_ready_q  <= 1'b0;
      ctrl_q     <= 1'b1;
      r_en_q     <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wa_q       <= '0;
      wb_q       <= '0;
      m_valid_q  <= 1'b0;
      m_result_q <= '0;
      m_cycles_q <= '0;
      m_error_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      s_ready_q  <= s_ready_d;
      ctrl_q     <= ctrl_d;
      r_en_q     <= r_en_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wa_q       <= wa_d;
      wb_q       <= wb_d;
      m_valid_q  <= m_valid_d;
      m_result_q <= m_result_d;
      m_cycles_q <= m_cycles_d;
      m_error_q  <= m_error_d;
    end
  end

  assign s_ready             = s_ready_q;
  assign m_valid             = m_valid_q;
  assign m_result            = m_result_q;
  assign m_cycles            = m_cycles_q;
  assign m_error             = m_error_q;
  assign controlArr          = ctrl_q;
  assign r_enable            = r_en_q;
  assign init_i_t_a          = '0;
  assign init_acc_t_a        = '0;
  assign controlArrWEnable_a = wen_q;
  assign controlArrWEnable_b = wen_q;
  assign controlArrAddr_a    = addr_q;
  assign controlArrAddr_b    = addr_q;
  assign controlArrWData_a   = wa_q;
  assign controlArrWData_b   = wb_q;

endmodule

// File: doc/dot_prod_host.md
# dot_prod_host

Hardware host for the generated dot-product kernel `main`. It accepts a stream of element pairs (a[i], b[i]) and writes them into the kernel's two array banks through the controlArr write ports. Unused addresses are zero-padded. It then pulses the kernel start, waits for completion, and returns the signed 64-bit result together with the kernel cycle count on an output handshake. It replaces host-side array loading so the kernel can be driven from on-chip producers.

## Interface

Parameters:
- ADDR_W, 10, array address width
- DEPTH, 1000, array length the kernel iterates over (≤ 2^ADDR_W)
- DATA_W, 27, signed element width
- ACC_W, 64, signed result width
- TIMEOUT, 2^20, maximum RUN cycles before an error completion

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- s_valid  in  1  input element valid
- s_ready  out  1  input element accepted when s_valid && s_ready
- s_a, s_b  in  DATA_W  signed element pair
- s_last  in  1  marks final element of a job
- m_valid  out  1  result available
- m_ready  in  1  result consumed when m_valid && m_ready
- m_result  out  ACC_W  signed kernel result
- m_cycles  out  32  kernel run length in cycles
- m_error  out  1  1 = timeout, m_result = 0
- controlArr  out  1  1 = host owns array ports
- r_enable  out  1  kernel start pulse
- init_i_t_a  out  ADDR_W  constant 0
- init_acc_t_a  out  ACC_W  constant 0
- w_enable  in  1  kernel done
- result  in  ACC_W  kernel result, valid with w_enable
- controlArrWEnable_a / _b  out  1  bank write enables
- controlArrAddr_a / _b  out  ADDR_W  bank addresses, always equal
- controlArrWData_a / _b  out  DATA_W  bank write data

## Operation

- States: LOAD, PAD, KICK, RUN, DONE.
- All kernel-side and m_* outputs are registered.
- LOAD
  - s_ready = 1, controlArr = 1.
  - Each accepted pair is written to address idx in both banks; idx then increments.
  - An accept with s_last = 1 ends the load. So does an accept at idx = DEPTH−1, regardless of s_last; the next element then starts a new job.
  - On end of load: go to PAD if idx+1 < DEPTH, otherwise go to KICK.
- PAD
  - s_ready = 0.
  - Writes 0 to both banks at idx, idx+1, …, DEPTH−1, one address per cycle, then goes to KICK.
- KICK
  - Emits the final registered write with controlArr still 1.
  - Next cycle: controlArr = 0, r_enable = 1 for exactly one cycle, write enables 0.
  - Then goes to RUN.
- RUN
  - Cycle counter runs.
  - w_enable sampled high captures result into m_result, m_error = 0, and goes to DONE.
  - Counter reaching TIMEOUT sets m_error = 1, m_result = 0, and goes to DONE.
- DONE
  - m_valid = 1. m_result, m_cycles and m_error are held stable until m_ready.
  - On the handshake: m_valid = 0, idx = 0, controlArr = 1, then back to LOAD.
- w_enable outside RUN is ignored.
- Arithmetic is done only by the kernel. The host forwards result unchanged (sign preserved) and sign-agnostic zero padding keeps stale data out of the sum.

## Timing

- Reset values:
  - s_ready = 0 in the reset cycle, 1 from the first LOAD cycle.
  - controlArr = 1.
  - r_enable = 0, write enables = 0, addresses = 0, write data = 0.
  - m_valid = 0, m_result = 0, m_cycles = 0, m_error = 0.
  - State = LOAD, idx = 0.
- Throughput: one element per cycle in LOAD, one pad per cycle in PAD.
- Write latency: an element accepted at edge e appears on the array ports from e to e+1 and commits at e+1.
- controlArr falls no earlier than the edge after the last write commits.
- m_cycles is the number of edges from the edge ending the r_enable cycle up to and including the edge that samples w_enable high. A kernel finishing one cycle after start gives 1.
- m_valid rises the cycle after w_enable is sampled.
- Job latency = N accepts + (DEPTH−N) pads + 2 + kernel cycles + 1.
- rst in any state (including mid-RUN or while m_valid is held) returns everything to reset values on the next edge. The kernel is not stopped; its pending w_enable is ignored.

## Test plan

- Full job: 1000 random pairs with s_valid held high and s_last on element 999 (uses the real `main`) -> m_result equals the bench 64-bit golden sum, m_error = 0, no pad writes observed.
- Short job: a = {1, 2, 3}, b = {4, 5, 6}, s_last on element 2 -> addresses 3..999 written 0 in both banks, m_result = 32.
- Extremes: 1000 pairs with a = b = −2^26 -> m_result = 4503599627370496000, with no truncation or sign loss.
- Output backpressure: m_ready held low 50 cycles after m_valid -> m_valid, m_result and m_cycles stable throughout; s_ready = 0 until the handshake; the next job is accepted on the following cycle.
- Timeout: stub kernel never asserts w_enable, TIMEOUT = 100 -> m_valid with m_error = 1 and m_result = 0 after 100 RUN cycles.
- Reset mid-operation: rst pulsed during PAD and again during RUN -> outputs at reset values the next cycle. A following 3-element job {1, 2, 3}·{4, 5, 6} returns 32. A late w_enable from the aborted run produces no m_valid.
